pool_flatten_ctrl: RTL and testbench

- Sequences CNN layer 1 (2x2 max-pool, stride 2) and layer 2 (flatten interleave) after the convolution engine has filled the layer-0 memories.
- Owns the shared result-memory port (csel/crd/caddr_rd/cdata_rd/cwr/caddr_wr/cdata_wr) while granted.
- Reads L0 kernel-0/1 images (64x64) and writes L1 kernel-0/1 images (32x32) plus the interleaved L2 vector (2048 words).
- The top-level CONV controller starts it and arbitrates the port via mem_req/mem_gnt.

---
 rtl/pool_flatten_ctrl_if.sv | 26 ++
 rtl/pool_flatten_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pool_flatten_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_flatten_ctrl_if.sv
// Result-memory port shared between the CONV controller and the pool/flatten sequencer.
// master = sequencer side (drives strobes/addresses), slave = memory/arbiter side.
interface pool_flatten_ctrl_if #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned ADDR_W = 12
);
    logic              mem_req;
    logic              mem_gnt;
    logic [2:0]        csel;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;

    modport master (
        output mem_req, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr,
        input  mem_gnt, cdata_rd
    );

    modport slave (
        input  mem_req, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr,
        output mem_gnt, cdata_rd
    );
endinterface

// File: rtl/pool_flatten_ctrl.sv
// CNN layer 1 (2x2 max-pool, stride 2) and layer 2 (flatten interleave) sequencer.
// Optional macro POOL_RELU_EN clamps negative pooled values to zero before they are written.
module pool_flatten_ctrl #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned DATA_W = 20,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    pool_flatten_ctrl_if.master mem
);

    localparam int unsigned L1_W = IMG_W / 2;
    localparam int unsigned NPIX = L1_W * L1_W;
    localparam int unsigned P_W  = $clog2(NPIX);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WRL1, S_WRL2, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_k;
    logic [P_W-1:0]    r_p;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_vld;
    logic              r_rd_first;
    logic [DATA_W-1:0] r_max;

    logic              w_gnt;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_pool;
    logic [ADDR_W-1:0] w_base;
    logic              w_crd;
    logic              w_cwr;
    logic [2:0]        w_csel;
    logic [ADDR_W-1:0] w_caddr_rd;
    logic [ADDR_W-1:0] w_caddr_wr;
    logic [DATA_W-1:0] w_cdata_wr;

    function automatic logic [DATA_W-1:0] f_relu(input logic [DATA_W-1:0] x);
`ifdef POOL_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign w_gnt  = mem.mem_gnt;
    assign w_max  = ($signed(mem.cdata_rd) > $signed(r_max)) ? mem.cdata_rd : r_max;
    assign w_pool = r_rd_vld ? w_max : r_max;
    // Top-left L0 address of the 2x2 window for L1 pixel p = r*L1_W + c
    assign w_base = ADDR_W'((32'(r_p) / L1_W) * 2 * IMG_W + (32'(r_p) % L1_W) * 2);

    // Port strobes decode the registered state and are gated by the grant in the same cycle
    always_comb begin
        w_crd      = 1'b0;
        w_cwr      = 1'b0;
        w_csel     = 3'd0;
        w_caddr_rd = '0;
        w_caddr_wr = '0;
        w_cdata_wr = '0;
        case (r_state)
            S_RD0: w_caddr_rd = w_base;
            S_RD1: w_caddr_rd = w_base + ADDR_W'(1);
            S_RD2: w_caddr_rd = w_base + ADDR_W'(IMG_W);
            S_RD3: w_caddr_rd = w_base + ADDR_W'(IMG_W + 1);
            default: w_caddr_rd = '0;
        endcase
        case (r_state)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                w_crd  = w_gnt;
                w_csel = w_gnt ? (3'd1 + 3'(r_k)) : 3'd0;
            end
            S_WRL1: begin
                w_cwr      = w_gnt;
                w_csel     = w_gnt ? (3'd3 + 3'(r_k)) : 3'd0;
                w_caddr_wr = ADDR_W'(r_p);
                w_cdata_wr = f_relu(w_pool);
            end
            S_WRL2: begin
                w_cwr      = w_gnt;
                w_csel     = w_gnt ? 3'd5 : 3'd0;
                w_caddr_wr = ADDR_W'({r_p, r_k});
                w_cdata_wr = f_relu(r_max);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= 1'b0;
            r_p        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_max      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_vld   <= w_crd;
            r_rd_first <= w_crd && (r_state == S_RD0);
            // Read data is captured the cycle after issue, regardless of the current grant
            if (r_rd_vld) begin
                r_max <= r_rd_first ? mem.cdata_rd : w_max;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RD0;
                        r_busy  <= 1'b1;
                        r_k     <= 1'b0;
                        r_p     <= '0;
                    end
                end
                S_RD0:  if (w_gnt) r_state <= S_RD1;
                S_RD1:  if (w_gnt) r_state <= S_RD2;
                S_RD2:  if (w_gnt) r_state <= S_RD3;
                S_RD3:  if (w_gnt) r_state <= S_WRL1;
                S_WRL1: if (w_gnt) r_state <= S_WRL2;
                S_WRL2: begin
                    if (w_gnt) begin
                        if (r_p != P_W'(NPIX - 1)) begin
                            r_p     <= r_p + 1'b1;
                            r_state <= S_RD0;
                        end else if (!r_k) begin
                            r_k     <= 1'b1;
                            r_p     <= '0;
                            r_state <= S_RD0;
                        end else begin
                            r_k     <= 1'b0;
                            r_p     <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem.mem_req  = r_busy;
    assign mem.crd      = w_crd;
    assign mem.cwr      = w_cwr;
    assign mem.csel     = w_csel;
    assign mem.caddr_rd = w_caddr_rd;
    assign mem.caddr_wr = w_caddr_wr;
    assign mem.cdata_wr = w_cdata_wr;

endmodule

// File: tb/tb_pool_flatten_ctrl.sv
// Bench for pool_flatten_ctrl: memory model, random images and grant, reference pooling model.
module tb_pool_flatten_ctrl;
    localparam int unsigned IMG_W  = 64;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned L1_W   = IMG_W / 2;
    localparam int unsigned NPIX   = L1_W * L1_W;
    localparam int          PASS_CYC = 2 * 1024 * 6 + 2;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    pool_flatten_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    pool_flatten_ctrl #(.IMG_W(IMG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .mem   (mem_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_bad = 0;
    int n_done = 0;
    int rd_ph = 0;
    bit after_rd3 = 1'b0;
    bit rand_gnt = 1'b0;
    bit clr_req = 1'b0;

    logic [DATA_W-1:0] l0 [2][4096];
    logic [DATA_W-1:0] l1 [2][NPIX];
    logic [DATA_W-1:0] l2 [2*NPIX];
    int                l1_hits [2][NPIX];
    int                l2_hits [2*NPIX];
    logic [DATA_W-1:0] snap_l1 [2][NPIX];
    logic [DATA_W-1:0] snap_l2 [2*NPIX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Result memories: read data one cycle after crd, writes committed at posedge
    always @(posedge clk) begin
        if (clr_req) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < int'(NPIX); p++) begin
                    l1[k][p]      <= 20'hAAAAA;
                    l1_hits[k][p] <= 0;
                end
            end
            for (int i = 0; i < int'(2*NPIX); i++) begin
                l2[i]      <= 20'hAAAAA;
                l2_hits[i] <= 0;
            end
        end else begin
            if (reset) begin
                rd_ph     <= 0;
                after_rd3 <= 1'b0;
            end else if (mem_if.crd) begin
                n_rd      <= n_rd + 1;
                rd_ph     <= (rd_ph + 1) % 4;
                after_rd3 <= (rd_ph == 3);
                if (mem_if.csel == 3'd1 || mem_if.csel == 3'd2)
                    mem_if.cdata_rd <= l0[mem_if.csel == 3'd2][mem_if.caddr_rd];
                else
                    n_bad <= n_bad + 1;
            end else begin
                after_rd3 <= 1'b0;
            end
            if (mem_if.cwr) begin
                n_wr <= n_wr + 1;
                if ((mem_if.csel == 3'd3 || mem_if.csel == 3'd4) && mem_if.caddr_wr < ADDR_W'(NPIX)) begin
                    l1[mem_if.csel == 3'd4][mem_if.caddr_wr[9:0]]      <= mem_if.cdata_wr;
                    l1_hits[mem_if.csel == 3'd4][mem_if.caddr_wr[9:0]] <= l1_hits[mem_if.csel == 3'd4][mem_if.caddr_wr[9:0]] + 1;
                end else if (mem_if.csel == 3'd5 && mem_if.caddr_wr < ADDR_W'(2*NPIX)) begin
                    l2[mem_if.caddr_wr[10:0]]      <= mem_if.cdata_wr;
                    l2_hits[mem_if.caddr_wr[10:0]] <= l2_hits[mem_if.caddr_wr[10:0]] + 1;
                end else begin
                    n_bad <= n_bad + 1;
                end
            end
        end
    end

    // Grant driver: held high, or 50% random with a forced low right after each RD3 read
    initial begin
        mem_if.mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rand_gnt)      mem_if.mem_gnt = 1'b1;
            else if (after_rd3) mem_if.mem_gnt = 1'b0;
            else                mem_if.mem_gnt = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (busy) chk("rd_wr_excl", 32'(mem_if.crd & mem_if.cwr), 32'd0);
        if (rand_gnt && !mem_if.mem_gnt)
            chk("gnt0_quiet", 32'({mem_if.crd, mem_if.cwr, mem_if.csel}), 32'd0);
    end

    function automatic logic [DATA_W-1:0] ref_pool(input int k, input int p);
        int a;
        int offs[3];
        logic signed [DATA_W-1:0] m;
        logic signed [DATA_W-1:0] v;
        offs = '{1, int'(IMG_W), int'(IMG_W) + 1};
        a = 2 * (p / int'(L1_W)) * int'(IMG_W) + 2 * (p % int'(L1_W));
        m = l0[k][a];
        for (int i = 0; i < 3; i++) begin
            v = l0[k][a + offs[i]];
            if (v > m) m = v;
        end
`ifdef POOL_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    task automatic clear_mem();
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
    endtask

    task automatic check_mem(input string name);
        logic [DATA_W-1:0] e;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < int'(NPIX); p++) begin
                e = ref_pool(k, p);
                chk($sformatf("%s_l1k%0d_%0d", name, k, p),
                    (32'(l1_hits[k][p]) << 24) | 32'(l1[k][p]), (32'd1 << 24) | 32'(e));
                chk($sformatf("%s_l2_%0d", name, 2*p + k),
                    (32'(l2_hits[2*p+k]) << 24) | 32'(l2[2*p+k]), (32'd1 << 24) | 32'(e));
            end
        end
    endtask

    task automatic do_pass(input string name, input bit check_time, input bit spam);
        int  t0, rd0, wr0, dn0;
        bit  seen;
        rd0 = n_rd;
        wr0 = n_wr;
        dn0 = n_done;
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy_on"}, 32'(busy), 32'd1);
        chk({name, "_req_on"}, 32'(mem_if.mem_req), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            start = spam && (i == 100 || i == 9000);
            @(posedge clk);
            #1;
            seen = done;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (check_time) chk({name, "_latency"}, 32'(cyc - t0), 32'(PASS_CYC));
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({name, "_reads"}, 32'(n_rd - rd0), 32'd8192);
        chk({name, "_writes"}, 32'(n_wr - wr0), 32'd4096);
        repeat (10) @(posedge clk);
        #1;
        chk({name, "_one_done"}, 32'(n_done - dn0), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_req",   32'(mem_if.mem_req), 32'd0);
        chk("rst_crd",   32'(mem_if.crd), 32'd0);
        chk("rst_cwr",   32'(mem_if.cwr), 32'd0);
        chk("rst_csel",  32'(mem_if.csel), 32'd0);
        chk("rst_ardd",  32'(mem_if.caddr_rd), 32'd0);
        chk("rst_awr",   32'(mem_if.caddr_wr), 32'd0);
        chk("rst_dwr",   32'(mem_if.cdata_wr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp image on kernel 0, constant on kernel 1, grant held high
        for (int a = 0; a < 4096; a++) begin
            l0[0][a] = DATA_W'(32'h10 * (a % 97));
            l0[1][a] = 20'h00005;
        end
        clear_mem();
        do_pass("A", 1'b1, 1'b0);
        check_mem("A");
        chk("A_l1k0_0",  32'(l1[0][0]), 32'h410);
        chk("A_l1k1_37", 32'(l1[1][37]), 32'h5);
        chk("A_l2_75",   32'(l2[75]), 32'h5);

        // Random image with a mixed-sign window at p=0 and an all-negative window at p=1
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4096; a++)
                l0[k][a] = DATA_W'($urandom);
        l0[0][0]  = 20'hFFFF0;
        l0[0][1]  = 20'h00003;
        l0[0][64] = 20'h80000;
        l0[0][65] = 20'h00002;
        l0[0][2]  = 20'hFFFF0;
        l0[0][3]  = 20'hFFFF0;
        l0[0][66] = 20'hFFFF0;
        l0[0][67] = 20'hFFFF0;
        clear_mem();
        do_pass("R1", 1'b1, 1'b0);
        check_mem("R1");
        chk("R1_signed_max", 32'(l1[0][0]), 32'h00003);
`ifdef POOL_RELU_EN
        chk("R1_neg_window", 32'(l1[0][1]), 32'h00000);
`else
        chk("R1_neg_window", 32'(l1[0][1]), 32'hFFFF0);
`endif
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < int'(NPIX); p++)
                snap_l1[k][p] = l1[k][p];
        for (int i = 0; i < int'(2*NPIX); i++)
            snap_l2[i] = l2[i];

        // Same image under a toggling grant must give identical memories
        clear_mem();
        rand_gnt = 1'b1;
        do_pass("R2", 1'b0, 1'b0);
        rand_gnt = 1'b0;
        check_mem("R2");
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < int'(NPIX); p++)
                chk($sformatf("R2_vs_R1_l1k%0d_%0d", k, p), 32'(l1[k][p]), 32'(snap_l1[k][p]));
        for (int i = 0; i < int'(2*NPIX); i++)
            chk($sformatf("R2_vs_R1_l2_%0d", i), 32'(l2[i]), 32'(snap_l2[i]));

        // Reset in the middle of a pass, then a clean pass with redundant start pulses
        clear_mem();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5000) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_crd",  32'(mem_if.crd), 32'd0);
        chk("mid_rst_cwr",  32'(mem_if.cwr), 32'd0);
        chk("mid_rst_req",  32'(mem_if.mem_req), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_mem();
        do_pass("RST", 1'b1, 1'b1);
        check_mem("RST");

        chk("bad_access", 32'(n_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
